bits_rx: RTL and testbench

Serial receiver for the muxed radar bit stream that the data bus emits on `bits`, together with its `mti_nv` tag. It sits at the consuming end of that stream and hunts for word alignment on `frame_sync`. It shifts in `WORD_W` bits MSB-first on `bit_en` strobes, tags each word with the MTI/NV selection captured at its first bit, and buffers completed words in a small FIFO behind a valid/ready handshake toward the display/processing logic.

---
 rtl/bits_rx_pkg.sv | 14 +
 rtl/bits_rx_if.sv | 30 +++
 rtl/bits_rx_sync_fifo.sv | 66 ++++++
 rtl/bits_rx.sv | 165 ++++++++++++++++
 tb/tb_bits_rx.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/bits_rx_pkg.sv
// bits_rx_pkg: shared definitions for the serial word receiver.
//   state_t : receiver FSM encoding (HUNT, SHIFT, PARITY)
//   OVF_W   : width of the saturating overflow counter
package bits_rx_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  localparam int OVF_W = 8;

endpackage

// File: rtl/bits_rx_if.sv
// bits_rx_if: valid/ready word stream from the receiver to its consumer.
//   word_data  : head word
//   word_mti   : MTI/NV tag of the head word
//   word_valid : head word present
//   word_ready : consumer accepts the head when valid & ready
// Modports: master (receiver side), slave (consumer side).
interface bits_rx_if #(
  parameter int WORD_W = 12
);

  logic [WORD_W-1:0] word_data;
  logic              word_mti;
  logic              word_valid;
  logic              word_ready;

  modport master (
    output word_data,
    output word_mti,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_mti,
    input  word_valid,
    output word_ready
  );

endinterface

// File: rtl/bits_rx_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count.
//   clk, rst   : clock, synchronous active-high reset
//   i_wr_en    : write request (accepted when not full, or when full and
//                a read is accepted in the same cycle)
//   i_wr_data  : write data
//   i_rd_en    : read request (head advances when not empty)
//   o_rd_data  : head entry
//   o_fill     : current occupancy
//   o_full     : occupancy == DEPTH
//   o_empty    : occupancy == 0
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_wr_en,
  input  logic [WIDTH-1:0]       i_wr_data,
  input  logic                   i_rd_en,
  output logic [WIDTH-1:0]       o_rd_data,
  output logic [$clog2(DEPTH):0] o_fill,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_fill;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_fill == (AW+1)'(DEPTH));
  assign o_empty = (r_fill == '0);
  assign w_rd    = i_rd_en & ~o_empty;
  // a read in the same cycle frees the slot this write lands in
  assign w_wr    = i_wr_en & (~o_full | w_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      // cleared so the head reads as zero out of reset
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_fill    = r_fill;

endmodule

// File: rtl/bits_rx.sv
// bits_rx: serial receiver for the muxed radar bit stream.
// Hunts for frame_sync, shifts WORD_W bits MSB-first on bit_en strobes,
// tags each word with mti_nv captured on its first bit and buffers
// completed words in a FIFO behind a valid/ready handshake.
//   clk, rst    : clock, synchronous active-high reset
//   bits        : serial data, sampled on bit_en
//   bit_en      : one-cycle bit strobe
//   frame_sync  : marks the MSB of a word (qualified by bit_en)
//   mti_nv      : stream tag, captured on the MSB bit
//   word_if     : word stream out (bits_rx_if master)
//   sync_err    : one-cycle pulse when a word is cut short by frame_sync
//   par_err     : one-cycle pulse on parity failure (0 without parity)
//   ovf_cnt     : saturating count of words dropped on FIFO full
//   fill        : FIFO occupancy
// Optional feature macro: BITS_RX_PARITY_EN adds an even-parity bit
// after the data bits.
module bits_rx
  import bits_rx_pkg::*;
#(
  parameter int WORD_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        bits,
  input  logic                        bit_en,
  input  logic                        frame_sync,
  input  logic                        mti_nv,
  bits_rx_if.master                   word_if,
  output logic                        sync_err,
  output logic                        par_err,
  output logic [OVF_W-1:0]            ovf_cnt,
  output logic [$clog2(FIFO_DEPTH):0] fill
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_shift;
  logic              r_tag;
  logic              r_push;
  logic              r_sync_err;
  logic [OVF_W-1:0]  r_ovf_cnt;

  logic [WORD_W:0]   w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_drop;

`ifdef BITS_RX_PARITY_EN
  logic              r_par_err;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_HUNT;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_tag      <= 1'b0;
      r_push     <= 1'b0;
      r_sync_err <= 1'b0;
`ifdef BITS_RX_PARITY_EN
      r_par_err  <= 1'b0;
`endif
    end else begin
      r_push     <= 1'b0;
      r_sync_err <= 1'b0;
`ifdef BITS_RX_PARITY_EN
      r_par_err  <= 1'b0;
`endif
      if (bit_en) begin
        unique case (r_state)
          ST_HUNT: begin
            if (frame_sync) begin
              r_shift <= {{(WORD_W-1){1'b0}}, bits};
              r_tag   <= mti_nv;
              r_cnt   <= CNT_W'(1);
              r_state <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (frame_sync) begin
              // misaligned: drop the partial word, this bit starts a new one
              r_sync_err <= 1'b1;
              r_shift    <= {{(WORD_W-1){1'b0}}, bits};
              r_tag      <= mti_nv;
              r_cnt      <= CNT_W'(1);
            end else begin
              r_shift <= {r_shift[WORD_W-2:0], bits};
              if (r_cnt == CNT_W'(WORD_W - 1)) begin
                r_cnt   <= '0;
`ifdef BITS_RX_PARITY_EN
                r_state <= ST_PARITY;
`else
                r_push  <= 1'b1;
                r_state <= ST_HUNT;
`endif
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
`ifdef BITS_RX_PARITY_EN
          ST_PARITY: begin
            if (frame_sync) begin
              r_sync_err <= 1'b1;
              r_shift    <= {{(WORD_W-1){1'b0}}, bits};
              r_tag      <= mti_nv;
              r_cnt      <= CNT_W'(1);
              r_state    <= ST_SHIFT;
            end else begin
              // even parity: data plus parity bit must XOR to zero
              if (^{r_shift, bits}) r_par_err <= 1'b1;
              else                  r_push    <= 1'b1;
              r_state <= ST_HUNT;
            end
          end
`endif
          default: r_state <= ST_HUNT;
        endcase
      end
    end
  end

  // r_shift/r_tag may already be reloaded by a back-to-back word on the
  // push edge; the FIFO samples the pre-edge values, which are the
  // completed word.
  sync_fifo #(
    .WIDTH (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (r_push),
    .i_wr_data ({r_tag, r_shift}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_fill    (fill),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign w_pop  = word_if.word_valid & word_if.word_ready;
  assign w_drop = r_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (rst)                            r_ovf_cnt <= '0;
    else if (w_drop && r_ovf_cnt != '1) r_ovf_cnt <= r_ovf_cnt + 1'b1;
  end

  assign word_if.word_valid = ~w_empty;
  assign word_if.word_data  = w_head[WORD_W-1:0];
  assign word_if.word_mti   = w_head[WORD_W];
  assign sync_err           = r_sync_err;
  assign ovf_cnt            = r_ovf_cnt;

`ifdef BITS_RX_PARITY_EN
  assign par_err = r_par_err;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_bits_rx.sv
module tb_bits_rx;

`ifdef BITS_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bits = 1'b0;
  logic       bit_en = 1'b0;
  logic       frame_sync = 1'b0;
  logic       mti_nv = 1'b0;
  logic       sync_err;
  logic       par_err;
  logic [7:0] ovf_cnt;
  logic [2:0] fill;

  int n_checks = 0;
  int n_errors = 0;
  int n_sync   = 0;
  int n_par    = 0;

  bits_rx_if #(.WORD_W(12)) u_if ();

  bits_rx #(
    .WORD_W     (12),
    .FIFO_DEPTH (4)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .bits       (bits),
    .bit_en     (bit_en),
    .frame_sync (frame_sync),
    .mti_nv     (mti_nv),
    .word_if    (u_if),
    .sync_err   (sync_err),
    .par_err    (par_err),
    .ovf_cnt    (ovf_cnt),
    .fill       (fill)
  );

  always #5 clk = ~clk;

  // count error pulse cycles so pulse width and count are both covered
  always @(negedge clk) begin
    if (sync_err) n_sync <= n_sync + 1;
    if (par_err)  n_par  <= n_par + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // called at a negedge; strobe lasts one cycle, then gap-1 idle cycles
  task automatic bit1(input logic b, input logic fs, input logic m, input int gap);
    bits       = b;
    bit_en     = 1'b1;
    frame_sync = fs;
    mti_nv     = m;
    @(negedge clk);
    bit_en     = 1'b0;
    frame_sync = 1'b0;
    bits       = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send_raw(input logic [11:0] d, input logic m, input int gap);
    for (int i = 11; i >= 0; i--)
      bit1(d[i], (i == 11), m, (i == 0) ? 1 : gap);
  endtask

  task automatic send_word(input logic [11:0] d, input logic m, input int gap);
    send_raw(d, m, gap);
    if (PAR) bit1(^d, 1'b0, m, 1);
  endtask

  task automatic pop1();
    u_if.word_ready = 1'b1;
    @(negedge clk);
    u_if.word_ready = 1'b0;
  endtask

  logic [11:0] exp_d [4];
  logic        exp_m [4];
  int          sync0;

  initial begin
    u_if.word_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_valid", u_if.word_valid, 0);
    check("rst_data",  u_if.word_data, 0);
    check("rst_mti",   u_if.word_mti, 0);
    check("rst_sync",  sync_err, 0);
    check("rst_par",   par_err, 0);
    check("rst_ovf",   ovf_cnt, 0);
    check("rst_fill",  fill, 0);

    // bits without frame_sync are ignored while hunting
    for (int i = 0; i < 4; i++) bit1(1'b1, 1'b0, 1'b1, 2);
    @(negedge clk);
    check("hunt_fill", fill, 0);

    // single word, slow strobes
    send_word(12'hA5C, 1'b1, 3);
    check("single_valid_n1", u_if.word_valid, 0);
    @(negedge clk);
    check("single_valid_n2", u_if.word_valid, 1);
    check("single_data", u_if.word_data, 12'hA5C);
    check("single_mti",  u_if.word_mti, 1);
    check("single_fill", fill, 1);
    pop1();
    check("single_pop_valid", u_if.word_valid, 0);
    check("single_pop_fill",  fill, 0);

    // resync: 5 bits of a word, then a new frame_sync restarts
    sync0 = n_sync;
    for (int i = 0; i < 5; i++) bit1(1'b1, (i == 0), 1'b1, 1);
    send_word(12'h123, 1'b0, 1);
    @(negedge clk);
    check("resync_pulses", n_sync - sync0, 1);
    check("resync_fill", fill, 1);
    check("resync_data", u_if.word_data, 12'h123);
    check("resync_mti",  u_if.word_mti, 0);
    pop1();
    check("resync_empty", fill, 0);

    // overflow: 6 back-to-back words into a depth-4 FIFO
    send_word(12'h111, 1'b0, 1);
    send_word(12'h222, 1'b1, 1);
    send_word(12'h333, 1'b0, 1);
    send_word(12'h444, 1'b1, 1);
    send_word(12'h555, 1'b0, 1);
    send_word(12'h666, 1'b1, 1);
    @(negedge clk);
    check("ovf_fill", fill, 4);
    check("ovf_cnt",  ovf_cnt, 2);
    check("ovf_head", u_if.word_data, 12'h111);

    // full plus pop on the push edge: both accepted
    send_word(12'h777, 1'b0, 1);
    u_if.word_ready = 1'b1;
    @(negedge clk);
    u_if.word_ready = 1'b0;
    check("fullpop_fill", fill, 4);
    check("fullpop_ovf",  ovf_cnt, 2);

    exp_d[0] = 12'h222; exp_m[0] = 1'b1;
    exp_d[1] = 12'h333; exp_m[1] = 1'b0;
    exp_d[2] = 12'h444; exp_m[2] = 1'b1;
    exp_d[3] = 12'h777; exp_m[3] = 1'b0;
    u_if.word_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", u_if.word_valid, 1);
      check("drain_data",  u_if.word_data, exp_d[k]);
      check("drain_mti",   u_if.word_mti, exp_m[k]);
      @(negedge clk);
    end
    u_if.word_ready = 1'b0;
    check("drain_empty", u_if.word_valid, 0);

    // reset with a buffered word and a partial word in flight
    send_word(12'h3C3, 1'b1, 1);
    for (int i = 0; i < 7; i++) bit1(1'b1, (i == 0), 1'b0, 1);
    sync0 = n_sync;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_valid", u_if.word_valid, 0);
    check("mrst_data",  u_if.word_data, 0);
    check("mrst_fill",  fill, 0);
    check("mrst_ovf",   ovf_cnt, 0);
    check("mrst_sync",  sync_err, 0);
    send_word(12'h0F0, 1'b0, 2);
    @(negedge clk);
    check("mrst_nosync", n_sync - sync0, 0);
    check("mrst_word",  u_if.word_data, 12'h0F0);
    check("mrst_wfill", fill, 1);
    pop1();

`ifdef BITS_RX_PARITY_EN
    send_raw(12'h001, 1'b0, 1);
    bit1(1'b0, 1'b0, 1'b0, 1);
    @(negedge clk);
    check("par_bad_pulses", n_par, 1);
    check("par_bad_fill", fill, 0);
    send_raw(12'h001, 1'b0, 1);
    bit1(1'b1, 1'b0, 1'b0, 1);
    @(negedge clk);
    check("par_good_pulses", n_par, 1);
    check("par_good_fill", fill, 1);
    check("par_good_data", u_if.word_data, 12'h001);
`else
    check("par_never", n_par, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
